// File: rtl/rop_types.sv
// Shared ROP types: CSR layout, DCR offset map and config FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rop_types;

    // DCR offsets relative to the block's DCR base address
    localparam int unsigned ROP_DCR_ZBUF_ADDR      = 0;
    localparam int unsigned ROP_DCR_ZBUF_PITCH     = 1;
    localparam int unsigned ROP_DCR_CBUF_ADDR      = 2;
    localparam int unsigned ROP_DCR_CBUF_PITCH     = 3;
    localparam int unsigned ROP_DCR_ZFUNC          = 4;
    localparam int unsigned ROP_DCR_SFUNC          = 5;
    localparam int unsigned ROP_DCR_ZFAIL          = 6;
    localparam int unsigned ROP_DCR_ZPASS          = 7;
    localparam int unsigned ROP_DCR_SFAIL          = 8;
    localparam int unsigned ROP_DCR_BLEND_MODE_RGB = 9;
    localparam int unsigned ROP_DCR_BLEND_MODE_A   = 10;
    localparam int unsigned ROP_DCR_BLEND_SRC_RGB  = 11;
    localparam int unsigned ROP_DCR_BLEND_SRC_A    = 12;
    localparam int unsigned ROP_DCR_BLEND_DST_RGB  = 13;
    localparam int unsigned ROP_DCR_BLEND_DST_A    = 14;
    localparam int unsigned ROP_DCR_BLEND_CONST    = 15;
    localparam int unsigned ROP_DCR_LOGIC_OP       = 16;
    localparam int unsigned ROP_DCR_COMMIT         = 17;
    localparam int unsigned ROP_DCR_COUNT          = 18;

    // Full configuration seen by the depth/stencil/blend datapath
    typedef struct packed {
        logic [31:0] zbuf_addr;
        logic [31:0] zbuf_pitch;
        logic [31:0] cbuf_addr;
        logic [31:0] cbuf_pitch;
        logic [2:0]  zfunc;
        logic [2:0]  sfunc;
        logic [2:0]  zfail;
        logic [2:0]  zpass;
        logic [2:0]  sfail;
        logic [2:0]  blend_mode_rgb;
        logic [2:0]  blend_mode_a;
        logic [3:0]  blend_src_rgb;
        logic [3:0]  blend_src_a;
        logic [3:0]  blend_dst_rgb;
        logic [3:0]  blend_dst_a;
        logic [31:0] blend_const;
        logic [3:0]  logic_op;
    } rop_csrs_t;

    typedef enum logic [1:0] {
        ROP_CFG_IDLE   = 2'd0,
        ROP_CFG_DRAIN  = 2'd1,
        ROP_CFG_COMMIT = 2'd2
    } rop_cfg_state_t;

endpackage

// File: rtl/rop_inflight_cnt.sv
// Saturating up/down occupancy counter for a pipeline (count, empty, full).
// Latency: count updates on the clock edge after inc/dec.
// Backpressure: none itself; callers gate inc with !full_o; dec at empty holds.
module rop_inflight_cnt #(
    parameter int MAX = 64,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         empty_o,
    output logic         full_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == W'(MAX));

    // Next count: simultaneous inc/dec cancel; saturate at both ends
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + W'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            count_d = count_q - W'(1);
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A retire with nothing in flight means the pipeline lost track of a fragment
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(dec_i && empty_o));

endmodule

// File: rtl/rop_csr_ctrl.sv
// ROP config controller: DCR writes land in a shadow set, COMMIT drains the pipe then swaps.
// Latency: shadow write +1 cycle; commit at zero occupancy updates active 2 cycles after strobe.
// Backpressure: frag_in_ready low while a commit drains/applies or pipeline holds MAX_INFLIGHT.
module rop_csr_ctrl
    import rop_types::*;
#(
    parameter logic [11:0] DCR_BASE     = 12'h100,
    parameter int          MAX_INFLIGHT = 64,
    parameter int          EPOCH_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dcr_wr_valid,
    input  logic [11:0]           dcr_wr_addr,
    input  logic [31:0]           dcr_wr_data,
    input  logic                  frag_in_valid,
    output logic                  frag_in_ready,
    input  logic                  frag_out_fire,
    output rop_csrs_t             rop_csrs,
    output logic                  commit_busy,
    output logic [EPOCH_BITS-1:0] epoch
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    rop_cfg_state_t        state_q, state_d;
    logic                  commit_pending_q;
    rop_csrs_t             shadow_q, shadow_d;
    rop_csrs_t             active_q;
    logic [EPOCH_BITS-1:0] epoch_q;

    logic [CNT_W-1:0]      inflight;
    logic                  cnt_empty;
    logic                  cnt_full;

    // Addresses below the base wrap to large offsets and fall out of range
    logic [11:0] dcr_off;
    logic        csr_wr;
    logic        commit_wr;
    logic        frag_in_fire;
    logic        drain_done;

    assign dcr_off      = dcr_wr_addr - DCR_BASE;
    assign csr_wr       = dcr_wr_valid && (dcr_off < 12'(ROP_DCR_COMMIT));
    assign commit_wr    = dcr_wr_valid && (dcr_off == 12'(ROP_DCR_COMMIT));

    assign frag_in_ready = !reset && (state_q == ROP_CFG_IDLE) && !cnt_full;
    assign frag_in_fire  = frag_in_valid && frag_in_ready;

    // Drain finishes on the cycle the last fragment retires, not one later
    assign drain_done = cnt_empty || ((inflight == CNT_W'(1)) && frag_out_fire);

    assign rop_csrs    = active_q;
    assign epoch       = epoch_q;
    assign commit_busy = (state_q != ROP_CFG_IDLE) || commit_pending_q;

    rop_inflight_cnt #(
        .MAX (MAX_INFLIGHT),
        .W   (CNT_W)
    ) u_inflight (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (frag_in_fire),
        .dec_i   (frag_out_fire),
        .count_o (inflight),
        .empty_o (cnt_empty),
        .full_o  (cnt_full)
    );

    // Decode DCR writes into the shadow set; narrow fields take data LSBs
    always_comb begin
        shadow_d = shadow_q;
        if (csr_wr) begin
            case (dcr_off)
                12'(ROP_DCR_ZBUF_ADDR):      shadow_d.zbuf_addr      = dcr_wr_data;
                12'(ROP_DCR_ZBUF_PITCH):     shadow_d.zbuf_pitch     = dcr_wr_data;
                12'(ROP_DCR_CBUF_ADDR):      shadow_d.cbuf_addr      = dcr_wr_data;
                12'(ROP_DCR_CBUF_PITCH):     shadow_d.cbuf_pitch     = dcr_wr_data;
                12'(ROP_DCR_ZFUNC):          shadow_d.zfunc          = dcr_wr_data[2:0];
                12'(ROP_DCR_SFUNC):          shadow_d.sfunc          = dcr_wr_data[2:0];
                12'(ROP_DCR_ZFAIL):          shadow_d.zfail          = dcr_wr_data[2:0];
                12'(ROP_DCR_ZPASS):          shadow_d.zpass          = dcr_wr_data[2:0];
                12'(ROP_DCR_SFAIL):          shadow_d.sfail          = dcr_wr_data[2:0];
                12'(ROP_DCR_BLEND_MODE_RGB): shadow_d.blend_mode_rgb = dcr_wr_data[2:0];
                12'(ROP_DCR_BLEND_MODE_A):   shadow_d.blend_mode_a   = dcr_wr_data[2:0];
                12'(ROP_DCR_BLEND_SRC_RGB):  shadow_d.blend_src_rgb  = dcr_wr_data[3:0];
                12'(ROP_DCR_BLEND_SRC_A):    shadow_d.blend_src_a    = dcr_wr_data[3:0];
                12'(ROP_DCR_BLEND_DST_RGB):  shadow_d.blend_dst_rgb  = dcr_wr_data[3:0];
                12'(ROP_DCR_BLEND_DST_A):    shadow_d.blend_dst_a    = dcr_wr_data[3:0];
                12'(ROP_DCR_BLEND_CONST):    shadow_d.blend_const    = dcr_wr_data;
                12'(ROP_DCR_LOGIC_OP):       shadow_d.logic_op       = dcr_wr_data[3:0];
                default:                     shadow_d                = shadow_q;
            endcase
        end
    end

    // Commit sequencing: IDLE -> DRAIN until empty -> one COMMIT cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ROP_CFG_IDLE:   if (commit_wr) state_d = ROP_CFG_DRAIN;
            ROP_CFG_DRAIN:  if (drain_done) state_d = ROP_CFG_COMMIT;
            ROP_CFG_COMMIT: state_d = commit_wr ? ROP_CFG_DRAIN : ROP_CFG_IDLE;
            default:        state_d = ROP_CFG_IDLE;
        endcase
    end

    // State, shadow and active registers; active copies pre-write shadow in COMMIT
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ROP_CFG_IDLE;
            commit_pending_q <= 1'b0;
            shadow_q         <= '0;
            active_q         <= '0;
            epoch_q          <= '0;
        end else begin
            state_q          <= state_d;
            commit_pending_q <= (state_q == ROP_CFG_COMMIT) && commit_wr;
            shadow_q         <= shadow_d;
            if (state_q == ROP_CFG_COMMIT) begin
                active_q <= shadow_q;
                epoch_q  <= epoch_q + EPOCH_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_rop_csr_ctrl.sv
// Randomized + directed bench for rop_csr_ctrl with scoreboard of committed configs.
// Latency: reference model advances once per clock edge.
// Backpressure: model decides fragment acceptance from its own occupancy and phase.
module tb_rop_csr_ctrl;
    import rop_types::*;

    localparam logic [11:0] BASE = 12'h100;
    localparam int          MAXF = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        dcr_wr_valid;
    logic [11:0] dcr_wr_addr;
    logic [31:0] dcr_wr_data;
    logic        frag_in_valid;
    logic        frag_in_ready;
    logic        frag_out_fire;
    rop_csrs_t   rop_csrs;
    logic        commit_busy;
    logic [7:0]  epoch;

    always #5 clk = ~clk;

    rop_csr_ctrl #(.DCR_BASE(BASE), .MAX_INFLIGHT(MAXF), .EPOCH_BITS(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .dcr_wr_valid  (dcr_wr_valid),
        .dcr_wr_addr   (dcr_wr_addr),
        .dcr_wr_data   (dcr_wr_data),
        .frag_in_valid (frag_in_valid),
        .frag_in_ready (frag_in_ready),
        .frag_out_fire (frag_out_fire),
        .rop_csrs      (rop_csrs),
        .commit_busy   (commit_busy),
        .epoch         (epoch)
    );

    // ---------------- reference model ----------------
    // phase: 0 = accepting, 1 = waiting for pipeline empty, 2 = applying
    int          m_phase;
    int          m_cnt;
    int          m_epoch;
    bit          m_pend;
    logic [31:0] m_shadow [17];

    typedef struct packed {
        logic [7:0] ep;
        rop_csrs_t  csrs;
    } exp_t;
    exp_t sbq[$];

    int passed = 0;
    int total  = 0;
    bit mon_en = 1'b0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    function automatic rop_csrs_t pack_shadow();
        rop_csrs_t c;
        c.zbuf_addr      = m_shadow[0];
        c.zbuf_pitch     = m_shadow[1];
        c.cbuf_addr      = m_shadow[2];
        c.cbuf_pitch     = m_shadow[3];
        c.zfunc          = m_shadow[4][2:0];
        c.sfunc          = m_shadow[5][2:0];
        c.zfail          = m_shadow[6][2:0];
        c.zpass          = m_shadow[7][2:0];
        c.sfail          = m_shadow[8][2:0];
        c.blend_mode_rgb = m_shadow[9][2:0];
        c.blend_mode_a   = m_shadow[10][2:0];
        c.blend_src_rgb  = m_shadow[11][3:0];
        c.blend_src_a    = m_shadow[12][3:0];
        c.blend_dst_rgb  = m_shadow[13][3:0];
        c.blend_dst_a    = m_shadow[14][3:0];
        c.blend_const    = m_shadow[15];
        c.logic_op       = m_shadow[16][3:0];
        return c;
    endfunction

    // Advance the model by one clock edge using the inputs that were applied
    task automatic model_edge();
        int  off;
        bit  cwr, acc, fire, ret;
        int  nxt;
        exp_t e;
        if (reset) begin
            if (m_epoch != 0) begin
                e.ep = 8'd0; e.csrs = '0;
                sbq.push_back(e);
            end
            m_phase = 0; m_cnt = 0; m_epoch = 0; m_pend = 0;
            foreach (m_shadow[i]) m_shadow[i] = '0;
            return;
        end
        off  = int'(12'(dcr_wr_addr - BASE));
        cwr  = dcr_wr_valid && off == 17;
        acc  = (m_phase == 0) && (m_cnt < MAXF);
        fire = frag_in_valid && acc;
        ret  = frag_out_fire && m_cnt > 0;
        nxt  = m_cnt + (fire ? 1 : 0) - (ret ? 1 : 0);
        if (m_phase == 2) begin
            m_epoch = (m_epoch + 1) % 256;
            e.ep = 8'(m_epoch); e.csrs = pack_shadow();
            sbq.push_back(e);
        end
        if (dcr_wr_valid && off < 17) m_shadow[off] = dcr_wr_data;
        m_pend = (m_phase == 2) && cwr;
        case (m_phase)
            0: if (cwr) m_phase = 1;
            1: if (nxt == 0) m_phase = 2;
            default: m_phase = cwr ? 1 : 0;
        endcase
        m_cnt = nxt;
    endtask

    // ---------------- monitor ----------------
    logic [7:0] last_ep;
    rop_csrs_t  last_csrs;

    initial begin
        exp_t e;
        last_ep = 8'd0;
        last_csrs = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("frag_in_ready", 256'(frag_in_ready),
                      256'(!reset && m_phase == 0 && m_cnt < MAXF));
                check("commit_busy", 256'(commit_busy), 256'(m_phase != 0 || m_pend));
                if (epoch !== last_ep) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_epoch_change", 256'(epoch), 256'(last_ep));
                        last_ep = epoch;
                    end else begin
                        e = sbq.pop_front();
                        check("epoch", 256'(epoch), 256'(e.ep));
                        check("rop_csrs_on_commit", 256'(rop_csrs), 256'(e.csrs));
                        last_ep = e.ep;
                        last_csrs = e.csrs;
                    end
                end else begin
                    check("rop_csrs_stable", 256'(rop_csrs), 256'(last_csrs));
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc(input bit r, input bit wv, input logic [11:0] a, input logic [31:0] d,
                       input bit fin, input bit fout);
        reset = r; dcr_wr_valid = wv; dcr_wr_addr = a; dcr_wr_data = d;
        frag_in_valid = fin; frag_out_fire = fout;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 12'h000, 32'h0, 0, 0);
    endtask

    task automatic wr_off(input int off, input logic [31:0] d);
        cyc(0, 1, BASE + 12'(off), d, 0, 0);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300 && (m_phase != 0 || m_pend); i++) idle(1);
        idle(2);
        check("commit_completes", 256'(m_phase == 0 && !m_pend), 256'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit wv, fin, fout;
        logic [11:0] a;
        reset = 1'b1; dcr_wr_valid = 0; dcr_wr_addr = '0; dcr_wr_data = '0;
        frag_in_valid = 0; frag_out_fire = 0;
        m_phase = 0; m_cnt = 0; m_epoch = 0; m_pend = 0;
        foreach (m_shadow[i]) m_shadow[i] = '0;
        @(negedge clk);
        cyc(1, 0, 12'h0, 32'h0, 0, 0);
        cyc(1, 0, 12'h0, 32'h0, 0, 0);
        mon_en = 1'b1;
        check("reset_epoch", 256'(epoch), 256'(0));
        check("reset_csrs", 256'(rop_csrs), 256'(0));

        // 1: basic commit at zero occupancy
        idle(1);
        wr_off(0, 32'h8000_0000);
        wr_off(17, 32'hDEAD_BEEF);
        idle(3);
        check("s1_zbuf_addr", 256'(rop_csrs.zbuf_addr), 256'(32'h8000_0000));
        check("s1_epoch", 256'(epoch), 256'(1));

        // 2: commit waits for three in-flight fragments to retire
        for (int i = 0; i < 3; i++) cyc(0, 0, 12'h0, 32'h0, 1, 0);
        wr_off(15, 32'hFF00_FF00);
        wr_off(17, 32'h0);
        idle(3);
        check("s2_blend_const_held", 256'(rop_csrs.blend_const), 256'(0));
        for (int i = 0; i < 3; i++) cyc(0, 0, 12'h0, 32'h0, 1, 1);
        idle(2);
        check("s2_blend_const", 256'(rop_csrs.blend_const), 256'(32'hFF00_FF00));
        check("s2_epoch", 256'(epoch), 256'(2));

        // 3: occupancy ceiling
        for (int i = 0; i < MAXF - 1; i++) cyc(0, 0, 12'h0, 32'h0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 12'h0, 32'h0, 1, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 12'h0, 32'h0, 1, 0);
        check("s3_full_ready", 256'(frag_in_ready), 256'(0));
        for (int i = 0; i < MAXF; i++) cyc(0, 0, 12'h0, 32'h0, 0, 1);
        wr_off(1, 32'h0000_0400);
        wr_off(17, 32'h0);
        wait_idle();

        // 4a: merged commit in drain, then a second commit during the apply cycle
        wr_off(4, 32'h1);
        for (int i = 0; i < 2; i++) cyc(0, 0, 12'h0, 32'h0, 1, 0);
        wr_off(17, 32'h0);
        wr_off(17, 32'h0);
        cyc(0, 0, 12'h0, 32'h0, 0, 1);
        cyc(0, 0, 12'h0, 32'h0, 0, 1);
        wr_off(17, 32'h0);
        wait_idle();
        check("s4a_epoch", 256'(epoch), 256'(5));
        // 4b: shadow write during the apply cycle is excluded
        wr_off(17, 32'h0);
        for (int i = 0; i < 10 && m_phase != 2; i++) idle(1);
        wr_off(4, 32'h3);
        idle(3);
        check("s4b_zfunc_excluded", 256'(rop_csrs.zfunc), 256'(1));
        wr_off(17, 32'h0);
        wait_idle();
        check("s4b_zfunc", 256'(rop_csrs.zfunc), 256'(3));

        // 5: out-of-range addresses are ignored
        cyc(0, 1, BASE + 12'd18, 32'hFFFF_FFFF, 0, 0);
        cyc(0, 1, BASE - 12'd1, 32'hFFFF_FFFF, 0, 0);
        wr_off(17, 32'h0);
        wait_idle();
        check("s5_zbuf_addr", 256'(rop_csrs.zbuf_addr), 256'(32'h8000_0000));

        // 6: reset in the middle of a drain
        for (int i = 0; i < 5; i++) cyc(0, 0, 12'h0, 32'h0, 1, 0);
        wr_off(17, 32'h0);
        idle(1);
        cyc(1, 0, 12'h0, 32'h0, 0, 0);
        check("s6_epoch", 256'(epoch), 256'(0));
        check("s6_csrs", 256'(rop_csrs), 256'(0));
        check("s6_busy", 256'(commit_busy), 256'(0));
        reset = 1'b0;
        #1;
        check("s6_ready", 256'(frag_in_ready), 256'(1));
        idle(1);

        // 7: random traffic
        for (int n = 0; n < 800; n++) begin
            wv = ($urandom_range(0, 99) < 20);
            k  = $urandom_range(0, 21);
            if (k == 21)      a = BASE - 12'd1;
            else if (k == 20) a = 12'hFFF;
            else              a = BASE + 12'(k);
            fin  = $urandom_range(0, 1) == 1;
            fout = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
            cyc(0, wv, a, $urandom, fin, fout);
        end
        while (m_cnt > 0) cyc(0, 0, 12'h0, 32'h0, 0, 1);
        wait_idle();
        check("scoreboard_drained", 256'(sbq.size()), 256'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
